// File: rtl/fetch_queue_unit_if.sv
// Decode-side handshake between the fetch queue head and the decode stage.
// The fetch unit drives the head entry; decode returns instr_ready.
interface fetch_queue_unit_if #(
  parameter int unsigned ADDR_WIDTH  = 64,
  parameter int unsigned INSTR_WIDTH = 32
);
  logic                   instr_valid;
  logic                   instr_ready;
  logic [INSTR_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0]  pc;
  logic [ADDR_WIDTH-1:0]  pc_plus4;
  logic                   pred_taken;
  logic [ADDR_WIDTH-1:0]  pred_target;

  modport master (
    output instr_valid, instr, pc, pc_plus4, pred_taken, pred_target,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr, pc, pc_plus4, pred_taken, pred_target,
    output instr_ready
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// Fetch stage: PC generation, icache lookup, miss refill FSM and a FQ_DEPTH-entry fetch queue.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_queue_unit #(
  parameter int unsigned          ADDR_WIDTH  = 64,
  parameter int unsigned          INSTR_WIDTH = 32,
  parameter int unsigned          BLOCK_WIDTH = 512,
  parameter int unsigned          FQ_DEPTH    = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_redirect,
  input  logic [ADDR_WIDTH-1:0]         i_redirect_pc,
  input  logic                          i_pred_taken,
  input  logic [ADDR_WIDTH-1:0]         i_pred_target,
  input  logic                          i_icache_hit,
  input  logic [INSTR_WIDTH-1:0]        i_icache_instr,
  input  logic                          i_refill_done,
  output logic [ADDR_WIDTH-1:0]         o_fetch_pc,
  output logic                          o_refill_req,
  output logic [ADDR_WIDTH-1:0]         o_refill_addr,
  output logic [$clog2(FQ_DEPTH):0]     o_fq_count,
  output logic [31:0]                   o_miss_cnt,
  output logic [31:0]                   o_full_cnt,
  fetch_queue_unit_if.master            dec
);

  localparam int unsigned PtrW = $clog2(FQ_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [ADDR_WIDTH-1:0] OffMask = ADDR_WIDTH'((BLOCK_WIDTH / 8) - 1);

  localparam logic [1:0] StFetch     = 2'd0;
  localparam logic [1:0] StMiss      = 2'd1;
  localparam logic [1:0] StMissAbort = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] refill_addr_q, refill_addr_d;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;

  logic [INSTR_WIDTH-1:0] instr_mem   [FQ_DEPTH];
  logic [ADDR_WIDTH-1:0]  pc_mem      [FQ_DEPTH];
  logic [ADDR_WIDTH-1:0]  pc4_mem     [FQ_DEPTH];
  logic                   taken_mem   [FQ_DEPTH];
  logic [ADDR_WIDTH-1:0]  target_mem  [FQ_DEPTH];

  logic push, pop, flush, full, miss_ev, full_ev;
  logic [ADDR_WIDTH-1:0] pc_plus4;

  assign pc_plus4 = pc_q + ADDR_WIDTH'(4);
  assign full     = (count_q == CntW'(FQ_DEPTH));
  assign pop      = dec.instr_valid & dec.instr_ready;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    refill_addr_d = refill_addr_q;
    push          = 1'b0;
    flush         = 1'b0;
    miss_ev       = 1'b0;
    full_ev       = 1'b0;
    if (i_redirect) begin
      flush = 1'b1;
      pc_d  = {i_redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      // An in-flight refill must still be waited out, just without using its result.
      state_d = ((state_q == StFetch) || i_refill_done) ? StFetch : StMissAbort;
    end else begin
      case (state_q)
        StFetch: begin
          if (i_icache_hit) begin
            if (!full) begin
              push = 1'b1;
              pc_d = i_pred_taken ? i_pred_target : pc_plus4;
            end else begin
              full_ev = 1'b1;
            end
          end else begin
            state_d       = StMiss;
            miss_ev       = 1'b1;
            refill_addr_d = pc_q & ~OffMask;
          end
        end
        StMiss, StMissAbort: begin
          if (i_refill_done) state_d = StFetch;
        end
        default: state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q       <= StFetch;
      pc_q          <= RESET_PC;
      refill_addr_q <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      refill_addr_q <= refill_addr_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
        count_q <= count_q + CntW'(push) - CntW'(pop);
      end
    end
  end

  // Payload storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge i_clk) begin
    if (push && i_rst_n) begin
      instr_mem[wr_ptr_q]  <= i_icache_instr;
      pc_mem[wr_ptr_q]     <= pc_q;
      pc4_mem[wr_ptr_q]    <= pc_plus4;
      taken_mem[wr_ptr_q]  <= i_pred_taken;
      target_mem[wr_ptr_q] <= i_pred_target;
    end
  end

  assign dec.instr_valid = (count_q != '0);
  assign dec.instr       = instr_mem[rd_ptr_q];
  assign dec.pc          = pc_mem[rd_ptr_q];
  assign dec.pc_plus4    = pc4_mem[rd_ptr_q];
  assign dec.pred_taken  = taken_mem[rd_ptr_q];
  assign dec.pred_target = target_mem[rd_ptr_q];

  assign o_fetch_pc    = pc_q;
  assign o_fq_count    = count_q;
  assign o_refill_req  = (state_q != StFetch);
  // Latched address keeps the refill stable even after a redirect moves the PC.
  assign o_refill_addr = (state_q == StFetch) ? (pc_q & ~OffMask) : refill_addr_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] miss_cnt_q, full_cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      miss_cnt_q <= '0;
      full_cnt_q <= '0;
    end else begin
      if (miss_ev && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
      if (full_ev && (full_cnt_q != '1)) full_cnt_q <= full_cnt_q + 32'd1;
    end
  end

  assign o_miss_cnt = miss_cnt_q;
  assign o_full_cnt = full_cnt_q;
  logic unused_lsb;
  assign unused_lsb = ^i_redirect_pc[1:0];
`else
  assign o_miss_cnt = '0;
  assign o_full_cnt = '0;
  logic unused_bits;
  assign unused_bits = ^{i_redirect_pc[1:0], miss_ev, full_ev};
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed self-checking bench for fetch_queue_unit: streaming, full queue, miss refill,
// redirect during miss, prediction and perf counters.
module tb_fetch_queue_unit;
  localparam int unsigned AW = 64;
  localparam int unsigned IW = 32;

  logic          clk;
  logic          rst_n;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          pred_taken;
  logic [AW-1:0] pred_target;
  logic          hit_en;
  logic          icache_hit;
  logic [IW-1:0] icache_instr;
  logic          refill_done;
  logic [AW-1:0] fetch_pc;
  logic          refill_req;
  logic [AW-1:0] refill_addr;
  logic [2:0]    fq_count;
  logic [31:0]   miss_cnt;
  logic [31:0]   full_cnt;
  logic          ready;

  int n_checks = 0;
  int n_errors = 0;

  fetch_queue_unit_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) dec_if ();

  fetch_queue_unit #(
    .ADDR_WIDTH (AW),
    .INSTR_WIDTH(IW),
    .BLOCK_WIDTH(512),
    .FQ_DEPTH   (4),
    .RESET_PC   (64'h1000)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .i_pred_taken  (pred_taken),
    .i_pred_target (pred_target),
    .i_icache_hit  (icache_hit),
    .i_icache_instr(icache_instr),
    .i_refill_done (refill_done),
    .o_fetch_pc    (fetch_pc),
    .o_refill_req  (refill_req),
    .o_refill_addr (refill_addr),
    .o_fq_count    (fq_count),
    .o_miss_cnt    (miss_cnt),
    .o_full_cnt    (full_cnt),
    .dec           (dec_if)
  );

  assign dec_if.instr_ready = ready;
  assign icache_hit   = hit_en;
  assign icache_instr = fetch_pc[31:0] ^ 32'hDEAD_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] exp_heads [5] = '{64'h1004, 64'h1008, 64'h100c, 64'h1010, 64'h1014};
  logic [31:0] exp_miss, exp_full;

  initial begin
`ifdef FETCH_PERF_CNT_EN
    exp_miss = 32'd3;
    exp_full = 32'd5;
`else
    exp_miss = 32'd0;
    exp_full = 32'd0;
`endif
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; pred_taken = 1'b0; pred_target = '0;
    hit_en = 1'b0; refill_done = 1'b0; ready = 1'b0;
    step(); step();
    check("rst_pc", fetch_pc, 64'h1000);
    check("rst_count", 64'(fq_count), 64'd0);
    check("rst_valid", 64'(dec_if.instr_valid), 64'd0);
    check("rst_req", 64'(refill_req), 64'd0);
    check("rst_miss_cnt", 64'(miss_cnt), 64'd0);
    check("rst_full_cnt", 64'(full_cnt), 64'd0);

    // Streaming hits with decode always ready.
    rst_n = 1'b1; hit_en = 1'b1; ready = 1'b1;
    step();
    check("stream_valid", 64'(dec_if.instr_valid), 64'd1);
    check("stream_pc0", dec_if.pc, 64'h1000);
    check("stream_pc4", dec_if.pc_plus4, 64'h1004);
    check("stream_instr", 64'(dec_if.instr), 64'hDEAD1000);
    step();
    check("stream_pc1", dec_if.pc, 64'h1004);
    check("stream_count", 64'(fq_count), 64'd1);
    step();
    check("stream_pc2", dec_if.pc, 64'h1008);

    // Flush and refill the queue to full with decode stalled.
    redirect = 1'b1; redirect_pc = 64'h1000; ready = 1'b0;
    step();
    check("flush_valid", 64'(dec_if.instr_valid), 64'd0);
    check("flush_pc", fetch_pc, 64'h1000);
    redirect = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("full_count", 64'(fq_count), 64'd4);
    check("full_pc", fetch_pc, 64'h1010);
    for (int i = 0; i < 4; i++) step();
    check("full_hold_pc", fetch_pc, 64'h1010);
    check("full_hold_count", 64'(fq_count), 64'd4);
    check("full_head", dec_if.pc, 64'h1000);
    ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("drain_head%0d", i), dec_if.pc, exp_heads[i]);
    end
    check("drain_pc", fetch_pc, 64'h1020);
    check("drain_count", 64'(fq_count), 64'd3);

    // Miss at 0x1044 and refill.
    redirect = 1'b1; redirect_pc = 64'h1044; hit_en = 1'b0;
    step();
    check("redir_pop_count", 64'(fq_count), 64'd0);
    check("redir_pc", fetch_pc, 64'h1044);
    redirect = 1'b0;
    step();
    check("miss_req", 64'(refill_req), 64'd1);
    check("miss_addr", refill_addr, 64'h1040);
    step(); step();
    check("miss_req_held", 64'(refill_req), 64'd1);
    check("miss_addr_held", refill_addr, 64'h1040);
    refill_done = 1'b1; hit_en = 1'b1;
    step();
    refill_done = 1'b0;
    check("done_req", 64'(refill_req), 64'd0);
    check("done_valid", 64'(dec_if.instr_valid), 64'd0);
    step();
    check("refetch_valid", 64'(dec_if.instr_valid), 64'd1);
    check("refetch_pc", dec_if.pc, 64'h1044);
    check("refetch_instr", 64'(dec_if.instr), 64'hDEAD1044);
    check("refetch_fpc", fetch_pc, 64'h1048);

    // Redirect while a refill is in flight.
    hit_en = 1'b0;
    step();
    check("miss2_req", 64'(refill_req), 64'd1);
    check("miss2_count", 64'(fq_count), 64'd0);
    redirect = 1'b1; redirect_pc = 64'h2002;
    step();
    redirect = 1'b0; hit_en = 1'b1;
    check("abort_pc", fetch_pc, 64'h2000);
    check("abort_req", 64'(refill_req), 64'd1);
    check("abort_addr", refill_addr, 64'h1040);
    step();
    check("abort_no_push", 64'(dec_if.instr_valid), 64'd0);
    check("abort_wait_req", 64'(refill_req), 64'd1);
    refill_done = 1'b1;
    step();
    refill_done = 1'b0;
    check("abort_done_req", 64'(refill_req), 64'd0);
    check("abort_no_stale", 64'(dec_if.instr_valid), 64'd0);
    step();
    check("abort_lookup_pc", dec_if.pc, 64'h2000);
    check("abort_next_fpc", fetch_pc, 64'h2004);

    // Predicted-taken branch.
    redirect = 1'b1; redirect_pc = 64'h1004; ready = 1'b0;
    step();
    check("pred_flush_count", 64'(fq_count), 64'd0);
    redirect = 1'b0; pred_taken = 1'b1; pred_target = 64'h3000;
    step();
    pred_taken = 1'b0;
    check("pred_fpc", fetch_pc, 64'h3000);
    check("pred_head_pc", dec_if.pc, 64'h1004);
    check("pred_head_taken", 64'(dec_if.pred_taken), 64'd1);
    check("pred_head_target", dec_if.pred_target, 64'h3000);

    // Third miss, then counters.
    hit_en = 1'b0;
    step();
    refill_done = 1'b1;
    step();
    refill_done = 1'b0;
    check("miss_cnt", 64'(miss_cnt), 64'(exp_miss));
    check("full_cnt", 64'(full_cnt), 64'(exp_full));

    // PC + 4 wraps at the top of the address space.
    redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE; hit_en = 1'b1;
    step();
    redirect = 1'b0;
    check("wrap_redir_pc", fetch_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    check("wrap_pc_plus4", dec_if.pc_plus4, 64'h0);
    check("wrap_fpc", fetch_pc, 64'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
